// File: rtl/mem_line_bridge.sv
// mem_line_bridge: splits one cache-line read/write into sequential beats on a narrow valid/ack bus.
module mem_line_bridge #(
  parameter int CACHE_LINE_SIZE = 512,
  parameter int MEM_BUS_WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 next_mem_load_type,
  input  logic [1:0]                 next_mem_store_type,
  input  logic [63:0]                mem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] mem_wdata,
  output logic [CACHE_LINE_SIZE-1:0] mem_rdata,
  output logic                       mem_ready,
  output logic                       bus_req,
  output logic                       bus_we,
  output logic [63:0]                bus_addr,
  output logic [MEM_BUS_WIDTH-1:0]   bus_wdata,
  input  logic                       bus_ack,
  input  logic [MEM_BUS_WIDTH-1:0]   bus_rdata
);
  localparam int BEATS = CACHE_LINE_SIZE / MEM_BUS_WIDTH;
  localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [1:0] IDLE = 2'd0, BEAT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [KW-1:0] k;
  logic op;
  logic [63:0] base;
  logic [CACHE_LINE_SIZE-1:0] line;
  logic start;
  assign start = (next_mem_store_type != '0) || (next_mem_load_type != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      k <= '0;
      op <= 1'b0;
      base <= '0;
      line <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op <= next_mem_store_type != '0;
          base <= mem_addr & ~64'(CACHE_LINE_SIZE / 8 - 1);
          line <= mem_wdata;
          k <= '0;
          state <= BEAT;
        end
        BEAT: if (bus_ack) begin
          if (!op) mem_rdata[int'(k)*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] <= bus_rdata;
          if (k == KW'(BEATS - 1)) state <= DONE;
          else k <= k + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  // All bus outputs decode from registers only, so stalls hold them stable.
  always_comb begin
    mem_ready = state == DONE;
    bus_req = state == BEAT;
    bus_we = bus_req & op;
    bus_addr = bus_req ? base + 64'(k) * 64'(MEM_BUS_WIDTH / 8) : '0;
    bus_wdata = bus_req ? line[int'(k)*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] : '0;
  end
endmodule

// File: doc/mem_line_bridge.md
# mem_line_bridge

Line-to-bus width adapter directly downstream of the L1 data cache. Takes one full cache-line request (read or write) from the L1 miss/write-back interface. Splits it into `CACHE_LINE_SIZE/MEM_BUS_WIDTH` sequential beats on a narrow valid/ack memory bus. Returns a single-cycle `mem_ready` pulse to L1 once all beats complete, with the assembled line on `mem_rdata` for reads.

## Interface
- `CACHE_LINE_SIZE`, 512, line width in bits; must be a multiple of `MEM_BUS_WIDTH`.
- `MEM_BUS_WIDTH`, 128, memory bus beat width in bits; must be a multiple of 8.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `next_mem_load_type`  in  mem_load_type_t  line read request when != NO_LOAD.
- `next_mem_store_type`  in  mem_store_type_t  line write request when != NO_STORE.
- `mem_addr`  in  64  line address; low `$clog2(CACHE_LINE_SIZE/8)` bits ignored (forced 0).
- `mem_wdata`  in  CACHE_LINE_SIZE  line to write.
- `mem_rdata`  out  CACHE_LINE_SIZE  assembled read line.
- `mem_ready`  out  1  one-cycle completion pulse.
- `bus_req`  out  1  beat request valid.
- `bus_we`  out  1  1 = write beat, 0 = read beat.
- `bus_addr`  out  64  byte address of current beat.
- `bus_wdata`  out  MEM_BUS_WIDTH  write beat data.
- `bus_ack`  in  1  beat accepted; for reads, `bus_rdata` valid in the same cycle.
- `bus_rdata`  in  MEM_BUS_WIDTH  read beat data.

## Operation
- `BEATS = CACHE_LINE_SIZE/MEM_BUS_WIDTH`. The beat counter is `max(1,$clog2(BEATS))` bits wide.
- FSM states: IDLE, BEAT, DONE.
- IDLE:
  - A store request has priority: if store != NO_STORE, the op is a write.
  - Otherwise, if load != NO_LOAD, the op is a read.
  - Otherwise, stay in IDLE.
  - On a request, capture base = `mem_addr` with offset bits cleared, capture `mem_wdata` and the op, clear the beat counter k, and go to BEAT.
- BEAT:
  - `bus_req`=1, `bus_we`=op, `bus_addr` = base + k·(MEM_BUS_WIDTH/8), `bus_wdata` = captured line[k·MEM_BUS_WIDTH +: MEM_BUS_WIDTH].
  - On `bus_ack`, for reads, write `bus_rdata` into `mem_rdata`[k·MEM_BUS_WIDTH +: MEM_BUS_WIDTH].
  - On `bus_ack`, if k == BEATS-1 go to DONE, else k++.
  - With `bus_ack`=0, all bus outputs are held stable.
- DONE:
  - `mem_ready`=1 for exactly one cycle, then go to IDLE unconditionally.
  - Request inputs are ignored in DONE, because L1 drops its request on the edge that samples `mem_ready`.
- `mem_rdata` holds the last completed read line until the next read overwrites it. Write ops do not modify `mem_rdata`.
- Inputs `mem_addr`/`mem_wdata` may change after capture without effect on the op in progress.
- Back-to-back ops (e.g. dirty write-back followed by refill): the second request is sampled in IDLE on the cycle after DONE.

## Timing
- Reset (async): state=IDLE, k=0, `mem_ready`=0, `mem_rdata`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0.
- Reset mid-op aborts the op immediately. No `mem_ready` pulse is issued for the aborted op.
- The request is sampled on edge E. `bus_req` is high from cycle E+1.
- With zero-wait `bus_ack`, beats complete on edges E+1…E+BEATS. `mem_ready` is high in cycle E+BEATS+1, i.e. 5 cycles after the request is visible at default parameters.
- Each `bus_ack`=0 cycle in BEAT adds exactly one cycle of latency.
- `bus_req`, `bus_we`, `bus_addr` and `bus_wdata` are driven from registered state only (no input-to-output combinational path). `bus_req` is 0 in IDLE and DONE.
- `bus_ack` while `bus_req`=0 is ignored.

## Test plan
- **Read, zero-wait:** load request, `mem_addr`=0x1234, `bus_ack` held 1, `bus_rdata` = beat index replicated.
  - Required: `bus_addr` = 0x1200, 0x1210, 0x1220, 0x1230 on consecutive cycles.
  - Required: `mem_ready` pulses once, 5 cycles after the request.
  - Required: `mem_rdata` = {3,2,1,0} beats.
- **Write with stalls:** store request, `mem_wdata` = 512'h(pattern), `bus_ack` low on alternate cycles.
  - Required: beats k=0..3 each carry line[k·128 +: 128] with `bus_we`=1, stable during stalls.
  - Required: `mem_ready` 8 cycles after the request; `mem_rdata` unchanged.
- **Write-back then refill:** store to 0x4000, then L1 switches to a load of 0x8000 after `mem_ready`.
  - Required: exactly 4 write beats, a single ready pulse, then 4 read beats at 0x8000..0x8030 and a second ready pulse.
  - Required: no duplicate write op.
- **Both types set:** store and load both != NONE.
  - Required: the op is performed as a write (`bus_we`=1).
- **Reset mid-op:** assert `rst` after 2 acked read beats.
  - Required: `bus_req`=0 and `mem_ready`=0 immediately, `mem_rdata`=0.
  - Required: after deassert, a new request restarts at beat 0.
- **Request change mid-op:** change `mem_addr`/`mem_wdata` during BEAT.
  - Required: bus addresses and data match the values captured at request time.
